// File: rtl/dm_block_copy.sv
// rtl/dm_block_copy.sv - forward data-memory block copy, one word per READ/WRITE pair.
// Optional running checksum of copied words is enabled by defining DM_COPY_CHECKSUM_EN.
module dm_block_copy #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_din,
  output logic          dm_we,
  input  logic [DW-1:0] dm_dout,
  output logic [DW-1:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_src_ptr;
  logic [AW-1:0] r_dst_ptr;
  logic [AW-1:0] r_remaining;
  logic [DW-1:0] r_data;
  logic          w_accept;
  logic          w_last;

  assign w_accept = (r_state == S_IDLE) && start && (len != '0);
  assign w_last   = (r_remaining == AW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (len != '0) ? S_READ : S_DONE;
      S_READ:  w_next = S_WRITE;
      S_WRITE: w_next = w_last ? S_DONE : S_READ;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Pointers wrap naturally at 2^AW; no range checking is intended.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_src_ptr   <= '0;
      r_dst_ptr   <= '0;
      r_remaining <= '0;
      r_data      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_src_ptr   <= src;
            r_dst_ptr   <= dst;
            r_remaining <= len;
          end
        end
        S_READ:  r_data <= dm_dout;
        S_WRITE: begin
          r_src_ptr   <= r_src_ptr + AW'(1);
          r_dst_ptr   <= r_dst_ptr + AW'(1);
          r_remaining <= r_remaining - AW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef DM_COPY_CHECKSUM_EN
  logic [DW-1:0] r_checksum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   r_checksum <= '0;
    else if (w_accept)            r_checksum <= '0;
    else if (r_state == S_WRITE)  r_checksum <= r_checksum + r_data;
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  // Outputs are pure state decodes so an async reset drops dm_we at once.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    dm_we   = 1'b0;
    dm_din  = '0;
    dm_addr = r_src_ptr;
    case (r_state)
      S_READ:  busy = 1'b1;
      S_WRITE: begin
        busy    = 1'b1;
        dm_we   = 1'b1;
        dm_din  = r_data;
        dm_addr = r_dst_ptr;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dm_block_copy.sv
// tb/tb_dm_block_copy.sv - self-checking bench for dm_block_copy against a word-array copy model.
module tb_dm_block_copy;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] src, dst, len;
  logic        busy, done, dm_we;
  logic [15:0] dm_addr, dm_din, dm_dout, checksum;

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [15:0] exp_sum;
  int tests = 0;
  int fails = 0;
  int cyc;
  bit saw_we, saw_busy, saw_rd0, saw_done;

  dm_block_copy #(.AW(16), .DW(16)) dut (
    .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we),
    .dm_dout(dm_dout), .checksum(checksum)
  );

  always #5 clk = ~clk;

  assign dm_dout = mem[dm_addr];
  always @(posedge clk) if (dm_we) mem[dm_addr] <= dm_din;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  // Reference: sequential ascending word copy; overlap propagates naturally.
  task automatic model_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
    logic [15:0] v;
    exp_sum = '0;
    for (int i = 0; i < int'(n); i++) begin
      v = ref_mem[16'(s + 16'(i))];
      ref_mem[16'(d + 16'(i))] = v;
      exp_sum = exp_sum + v;
    end
  endtask

  function automatic logic [15:0] exp_ck();
`ifdef DM_COPY_CHECKSUM_EN
    return exp_sum;
`else
    return 16'h0;
`endif
  endfunction

  task automatic check_mem(input string tag);
    int bad = 0;
    for (int a = 0; a < 65536; a++) if (mem[a] !== ref_mem[a]) bad++;
    check(tag, 32'(bad), 32'd0);
  endtask

  task automatic launch(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n, input bit hold);
    @(negedge clk);
    src = s; dst = d; len = n; start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      start = 1'b0;
      src = 16'($urandom); dst = 16'($urandom); len = 16'($urandom);
    end
  endtask

  // Counts cycles after the start edge; first sample point is cycle 'first'.
  task automatic wait_done(input int first, output int c_out);
    saw_we = 0; saw_busy = 0; saw_rd0 = 0;
    c_out = -1;
    for (int c = first; c <= 300; c++) begin
      @(negedge clk);
      if (dm_we) saw_we = 1;
      if (busy) saw_busy = 1;
      if (busy && !dm_we && dm_addr == 16'h0000) saw_rd0 = 1;
      if (done) begin c_out = c; break; end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
    for (int a = 0; a < 65536; a++) begin
      mem[a] = 16'($urandom);
      ref_mem[a] = mem[a];
    end
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_we", 32'(dm_we), 0);
    check("rst_din", 32'(dm_din), 0);
    check("rst_addr", 32'(dm_addr), 0);
    check("rst_ck", 32'(checksum), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    // Basic two-word copy
    poke(16'd0, 16'd8); poke(16'd1, 16'd5);
    model_copy(16'd0, 16'd4, 16'd2);
    launch(16'd0, 16'd4, 16'd2, 0);
    wait_done(1, cyc);
    check("basic_lat", 32'(cyc), 5);
    check("basic_ck", 32'(checksum), 32'(exp_ck()));
    @(negedge clk);
    check("basic_m4", 32'(mem[4]), 8);
    check("basic_m5", 32'(mem[5]), 5);
    check("basic_ck_hold", 32'(checksum), 32'(exp_ck()));

    // Zero length: straight to DONE, no access
    launch(16'h0300, 16'h0400, 16'd0, 0);
    wait_done(1, cyc);
    check("len0_lat", 32'(cyc), 1);
    check("len0_we", 32'(saw_we), 0);
    check("len0_busy", 32'(saw_busy), 0);
    @(negedge clk);
    check_mem("len0_mem");

    // Source pointer wraps past 0xFFFF
    poke(16'hFFFF, 16'h1234); poke(16'h0000, 16'hABCD);
    model_copy(16'hFFFF, 16'h0010, 16'd2);
    launch(16'hFFFF, 16'h0010, 16'd2, 0);
    wait_done(1, cyc);
    check("wrap_lat", 32'(cyc), 5);
    check("wrap_rd0", 32'(saw_rd0), 1);
    @(negedge clk);
    check("wrap_m10", 32'(mem[16'h10]), 16'h1234);
    check("wrap_m11", 32'(mem[16'h11]), 16'hABCD);

    // Overlapping forward copy propagates first word
    for (int i = 0; i < 4; i++) poke(16'(i), 16'(i + 1));
    model_copy(16'd0, 16'd1, 16'd3);
    launch(16'd0, 16'd1, 16'd3, 0);
    wait_done(1, cyc);
    check("ovl_lat", 32'(cyc), 7);
    check("ovl_ck", 32'(checksum), 32'(exp_ck()));
    @(negedge clk);
    check("ovl_m1", 32'(mem[1]), 1);
    check("ovl_m2", 32'(mem[2]), 1);
    check("ovl_m3", 32'(mem[3]), 1);

    // start held high: exactly one copy, next one accepted after DONE->IDLE
    model_copy(16'h0500, 16'h0600, 16'd3);
    launch(16'h0500, 16'h0600, 16'd3, 1);
    wait_done(1, cyc);
    check("hold_lat", 32'(cyc), 7);
    @(negedge clk);
    check("hold_idle_busy", 32'(busy), 0);
    check("hold_idle_done", 32'(done), 0);
    @(negedge clk);
    check("hold_restart", 32'(busy), 1);
    start = 1'b0;
    model_copy(16'h0500, 16'h0600, 16'd3);
    wait_done(2, cyc);
    check("hold_lat2", 32'(cyc), 7);
    @(negedge clk);
    check_mem("hold_mem");

    // Reset during first WRITE abandons copy
    launch(16'h0700, 16'h0800, 16'd4, 0);
    @(negedge clk);
    @(negedge clk);
    check("rstw_we_before", 32'(dm_we), 1);
    #1 reset = 1'b0;
    #1;
    check("rstw_we", 32'(dm_we), 0);
    check("rstw_busy", 32'(busy), 0);
    check("rstw_addr", 32'(dm_addr), 0);
    check("rstw_ck", 32'(checksum), 0);
    saw_done = 0;
    repeat (3) begin @(negedge clk); if (done) saw_done = 1; end
    reset = 1'b1;
    repeat (3) begin @(negedge clk); if (done) saw_done = 1; end
    check("rstw_nodone", 32'(saw_done), 0);
    check_mem("rstw_mem");

    // Randomized copies after reset
    for (int t = 0; t < 8; t++) begin
      logic [15:0] s, d, n;
      s = 16'($urandom); d = 16'($urandom);
      if (t % 3 == 0) d = s + 16'($urandom_range(1, 4));
      n = 16'($urandom_range(1, 12));
      model_copy(s, d, n);
      launch(s, d, n, 0);
      wait_done(1, cyc);
      check($sformatf("rnd%0d_lat", t), 32'(cyc), 32'(2 * int'(n) + 1));
      check($sformatf("rnd%0d_ck", t), 32'(checksum), 32'(exp_ck()));
      @(negedge clk);
      check_mem($sformatf("rnd%0d_mem", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dm_block_copy.md
DM_BLOCK_COPY -- requirements
Module: dm_block_copy

Interface
REQ-001 The module SHALL have parameter AW, default 16, the data-memory address width.
REQ-002 The module SHALL have parameter DW, default 16, the data-memory word width.
REQ-003 The module SHALL have port clk, input, 1 bit, the clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit, the reset; asynchronous, active-low.
REQ-005 The module SHALL have port start, input, 1 bit, a copy request sampled in IDLE only.
REQ-006 The module SHALL have port src, input, AW bits, the source base address, latched on accepted start.
REQ-007 The module SHALL have port dst, input, AW bits, the destination base address, latched on accepted start.
REQ-008 The module SHALL have port len, input, AW bits, the word count, latched on accepted start.
REQ-009 The module SHALL have port busy, output, 1 bit, high in READ and WRITE.
REQ-010 The module SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-011 The module SHALL have port dm_addr, output, AW bits, the data-memory address.
REQ-012 The module SHALL have port dm_din, output, DW bits, the data-memory write data.
REQ-013 The module SHALL have port dm_we, output, 1 bit, the data-memory write enable.
REQ-014 The module SHALL have port dm_dout, input, DW bits, the data-memory read data, combinational from dm_addr.
REQ-015 The module SHALL have port checksum, output, DW bits, the running sum of copied words.

Function
REQ-016 The FSM SHALL have exactly four states (IDLE, READ, WRITE, DONE), encoded in registers.
REQ-017 In IDLE, start=1 with len!=0 SHALL latch src, dst and len, clear checksum, and enter READ on the next edge.
REQ-018 In IDLE, start=1 with len==0 SHALL enter DONE directly, with no memory access.
REQ-019 In READ, the module SHALL drive dm_addr=src_ptr and dm_we=0, capture dm_dout into data_r at the edge, and go to WRITE.
REQ-020 In WRITE, the module SHALL drive dm_addr=dst_ptr, dm_din=data_r and dm_we=1; at the edge it SHALL increment src_ptr and dst_ptr, decrement remaining, and go to DONE if remaining was 1, else to READ.
REQ-021 In DONE, the module SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-022 The copy SHALL be start-to-done latency 2*len+1 cycles, counting the start edge as cycle 0 and done high in cycle 2*len+1.
REQ-023 dm_we SHALL be 1 only in WRITE, decoded from state; in all other states dm_we=0, dm_din=0 and dm_addr=src_ptr.
REQ-024 Pointer arithmetic SHALL be modulo 2^AW, so 0xFFFF+1 wraps to 0x0000 with no error.
REQ-025 The copy SHALL always be forward (ascending); for overlapping regions with dst>src, each write precedes the later read of the same address (defined overwrite propagation).
REQ-026 start SHALL be ignored outside IDLE, and src, dst and len SHALL be ignored outside IDLE.
REQ-027 busy SHALL be 0 in IDLE and DONE.

Reset
REQ-028 An asserted reset (low) SHALL immediately force the state to IDLE and clear data_r, the pointers, remaining and checksum, making outputs busy=0, done=0, dm_we=0, dm_din=0, dm_addr=0 and checksum=0.
REQ-029 A reset during READ or WRITE SHALL abandon the copy, drop dm_we without waiting for a clock edge, and produce no done pulse.
REQ-030 After reset is released, the first accepted start SHALL behave as from power-up.

Configuration
REQ-031 The checksum feature SHALL be controlled by the macro DM_COPY_CHECKSUM_EN.
REQ-032 With DM_COPY_CHECKSUM_EN defined, each WRITE edge SHALL add data_r to checksum modulo 2^DW, and the value SHALL hold from DONE until the next accepted start.
REQ-033 With DM_COPY_CHECKSUM_EN undefined, checksum SHALL be constant 0, no adder logic SHALL be instantiated, and all other behaviour SHALL be identical.

Verification
REQ-034 Bench memory model preloaded mem[0]=8, mem[1]=5; start with src=0, dst=4, len=2 -> mem[4]=8, mem[5]=5, done high in cycle 5, checksum=13 (with macro) or 0 (without).
REQ-035 start with len=0 -> done high in cycle 1, dm_we never asserted, busy never high.
REQ-036 src=0xFFFF, dst=0x0010, len=2 with mem[0xFFFF]=0x1234 and mem[0]=0xABCD -> mem[0x10]=0x1234, mem[0x11]=0xABCD, and the read address wraps to 0x0000.
REQ-037 Overlap case src=0, dst=1, len=3 with mem[0..3]=1,2,3,4 -> mem[1..3]=1,1,1.
REQ-038 Reset pulled low in the first WRITE of a len=4 copy -> dm_we=0 immediately, no done pulse, only addresses dst and earlier modified, and a new start after release completes normally.
REQ-039 start held high continuously during a len=3 copy -> a single copy runs, and a second copy starts only on the edge after DONE.
